// File: rtl/silife_grid_load_master.sv
// Grid load serial master: turns row-write, control-write and enumerate
// commands into CS/CLK/DATA frames for the per-segment grid loaders.
module silife_grid_load_master #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_type,
    input  logic [14:0]      i_cmd_segment,
    input  logic [15:0]      i_cmd_row,
    input  logic [WIDTH-1:0] i_cmd_cells,
    input  logic [23:0]      i_cmd_ctrl_addr,
    input  logic [31:0]      i_cmd_ctrl_data,
    input  logic             i_cmd_last,
    output logic             o_load_cs,
    output logic             o_load_clk,
    output logic             o_load_data,
    output logic             o_busy
);

    // Shift register fits the longest frame piece: header plus the larger payload.
    localparam int unsigned PAY_W = (WIDTH > 64) ? WIDTH : 64;
    localparam int unsigned SR_W  = 32 + PAY_W;
    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] LOW_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BIT_END = DIV_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT, S_HOLD, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [15:0]       bits_q, bits_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              fill_q, fill_d;
    logic [1:0]        type_q, type_d;
    logic              last_q, last_d;
    logic              pend_valid_q, pend_valid_d;
    logic              cs_d, sclk_d, data_d, ready_d, busy_d;
    logic              start, pend_load;

    logic [1:0]        pend_type_q;
    logic [14:0]       pend_seg_q;
    logic [15:0]       pend_row_q;
    logic [WIDTH-1:0]  pend_cells_q;
    logic [23:0]       pend_addr_q;
    logic [31:0]       pend_data_q;
    logic              pend_last_q;

    logic              use_pend, with_hdr, accept;
    logic [1:0]        src_type;
    logic [14:0]       src_seg;
    logic [15:0]       src_row;
    logic [WIDTH-1:0]  src_cells;
    logic [23:0]       src_addr;
    logic [31:0]       src_data;
    logic              src_last;
    logic [SR_W-1:0]   ld_sr;
    logic [15:0]       ld_bits;
    logic              ld_fill;

    assign accept = i_cmd_valid && o_cmd_ready;

    // Build the left-aligned bit stream for the command about to be launched.
    always_comb begin
        use_pend  = (state_q == S_GAP);
        with_hdr  = (state_q != S_WAIT);
        src_type  = use_pend ? pend_type_q  : i_cmd_type;
        src_seg   = use_pend ? pend_seg_q   : i_cmd_segment;
        src_row   = use_pend ? pend_row_q   : i_cmd_row;
        src_cells = use_pend ? pend_cells_q : i_cmd_cells;
        src_addr  = use_pend ? pend_addr_q  : i_cmd_ctrl_addr;
        src_data  = use_pend ? pend_data_q  : i_cmd_ctrl_data;
        src_last  = use_pend ? pend_last_q  : i_cmd_last;
        ld_sr     = '0;
        ld_bits   = '0;
        ld_fill   = 1'b0;
        case (src_type)
            2'd0: begin
                if (with_hdr) begin
                    ld_sr   = SR_W'({1'b0, src_seg, src_row, src_cells}) << (SR_W - 32 - WIDTH);
                    ld_bits = 16'(32 + WIDTH - 1);
                end else begin
                    ld_sr   = SR_W'(src_cells) << (SR_W - WIDTH);
                    ld_bits = 16'(WIDTH - 1);
                end
            end
            2'd1: begin
                if (with_hdr) begin
                    ld_sr   = SR_W'({1'b0, src_seg, 16'hFFFF, 8'h00, src_addr, src_data}) << (SR_W - 96);
                    ld_bits = 16'd95;
                end else begin
                    ld_sr   = SR_W'({8'h00, src_addr, src_data}) << (SR_W - 64);
                    ld_bits = 16'd63;
                end
            end
            default: begin
                // Enumerate: leading 1 then N more ones; bit counter holds N.
                ld_sr   = '1;
                ld_bits = 16'(src_seg);
                ld_fill = 1'b1;
            end
        endcase
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bits_d       = bits_q;
        sr_d         = sr_q;
        fill_d       = fill_q;
        type_d       = type_q;
        last_d       = last_q;
        pend_valid_d = pend_valid_q;
        cs_d         = o_load_cs;
        sclk_d       = o_load_clk;
        data_d       = o_load_data;
        start        = 1'b0;
        pend_load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && i_cmd_type != 2'd3) start = 1'b1;
            end
            S_SHIFT: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == LOW_END) sclk_d = 1'b1;
                if (div_q == BIT_END) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    if (bits_q != 16'd0) begin
                        bits_d = bits_q - 16'd1;
                        sr_d   = {sr_q[SR_W-2:0], fill_q};
                        data_d = sr_q[SR_W-2];
                    end else if (last_q) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (accept && i_cmd_type != 2'd3) begin
                    if (i_cmd_type == type_q && i_cmd_type != 2'd2) begin
                        start = 1'b1;
                    end else begin
                        pend_load    = 1'b1;
                        pend_valid_d = 1'b1;
                        state_d      = S_HOLD;
                        div_d        = '0;
                    end
                end
            end
            S_HOLD: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == LOW_END) begin
                    cs_d    = 1'b1;
                    state_d = S_GAP;
                    div_d   = '0;
                end
            end
            S_GAP: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == BIT_END) begin
                    div_d = '0;
                    if (pend_valid_q) begin
                        start        = 1'b1;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_SHIFT;
            div_d   = '0;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            sr_d    = ld_sr;
            bits_d  = ld_bits;
            fill_d  = ld_fill;
            data_d  = ld_sr[SR_W-1];
            type_d  = src_type;
            last_d  = src_last || (src_type == 2'd2);
        end
        ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE);
    end

    // Sequencer state and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bits_q       <= '0;
            sr_q         <= '0;
            fill_q       <= 1'b0;
            type_q       <= 2'd0;
            last_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            o_load_cs    <= 1'b1;
            o_load_clk   <= 1'b0;
            o_load_data  <= 1'b0;
            o_cmd_ready  <= 1'b1;
            o_busy       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bits_q       <= bits_d;
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            type_q       <= type_d;
            last_q       <= last_d;
            pend_valid_q <= pend_valid_d;
            o_load_cs    <= cs_d;
            o_load_clk   <= sclk_d;
            o_load_data  <= data_d;
            o_cmd_ready  <= ready_d;
            o_busy       <= busy_d;
        end
    end

    // Command that forced a frame close, replayed as a new frame after the gap.
    always_ff @(posedge clk) begin
        if (pend_load) begin
            pend_type_q  <= i_cmd_type;
            pend_seg_q   <= i_cmd_segment;
            pend_row_q   <= i_cmd_row;
            pend_cells_q <= i_cmd_cells;
            pend_addr_q  <= i_cmd_ctrl_addr;
            pend_data_q  <= i_cmd_ctrl_data;
            pend_last_q  <= i_cmd_last;
        end
    end

endmodule

// File: tb/tb_silife_grid_load_master.sv
// Bench for silife_grid_load_master: a pin monitor decodes frames into a
// queue, tasks push expected frames and compare them as frames complete.
module tb_silife_grid_load_master;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned CLK_DIV = 2;

    typedef struct {
        int           len;
        logic [255:0] bits;
        int           cs_cycles;
    } frame_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_type = '0;
    logic [14:0]      cmd_segment = '0;
    logic [15:0]      cmd_row = '0;
    logic [WIDTH-1:0] cmd_cells = '0;
    logic [23:0]      cmd_ctrl_addr = '0;
    logic [31:0]      cmd_ctrl_data = '0;
    logic             cmd_last = 1'b0;
    logic             load_cs, load_clk, load_data, busy;

    int checks = 0;
    int errors = 0;

    frame_t       obs_q[$];
    frame_t       exp_q[$];
    int           cur_len = 0;
    logic [255:0] cur_bits = '0;
    int           cs_cnt = 0;
    int           hi_cnt = 0;
    int           last_gap = 0;

    silife_grid_load_master #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_type     (cmd_type),
        .i_cmd_segment  (cmd_segment),
        .i_cmd_row      (cmd_row),
        .i_cmd_cells    (cmd_cells),
        .i_cmd_ctrl_addr(cmd_ctrl_addr),
        .i_cmd_ctrl_data(cmd_ctrl_data),
        .i_cmd_last     (cmd_last),
        .o_load_cs      (load_cs),
        .o_load_clk     (load_clk),
        .o_load_data    (load_data),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Loader-side view: sample data on rising serial clock while selected.
    always @(posedge load_clk) begin
        if (load_cs === 1'b0) begin
            cur_bits = {cur_bits[254:0], load_data};
            cur_len  = cur_len + 1;
        end
    end

    // Close a frame when CS rises.
    always @(posedge load_cs) begin
        frame_t f;
        if (cur_len > 0) begin
            f.len       = cur_len;
            f.bits      = cur_bits;
            f.cs_cycles = cs_cnt;
            obs_q.push_back(f);
        end
        cur_len  = 0;
        cur_bits = '0;
        cs_cnt   = 0;
    end

    always @(negedge load_cs) begin
        last_gap = hi_cnt;
        hi_cnt   = 0;
    end

    always @(posedge clk) begin
        if (load_cs === 1'b0) cs_cnt = cs_cnt + 1;
        if (load_cs === 1'b1) hi_cnt = hi_cnt + 1;
    end

    task automatic send(input logic [1:0] t, input logic [14:0] seg, input logic [15:0] row,
                        input logic [31:0] cells, input logic [23:0] addr,
                        input logic [31:0] dat, input logic last);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = t; cmd_segment = seg; cmd_row = row;
        cmd_cells = cells; cmd_ctrl_addr = addr; cmd_ctrl_data = dat; cmd_last = last;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL send_ready_timeout: ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_type = 2'($urandom); cmd_segment = 15'($urandom); cmd_row = 16'($urandom);
        cmd_cells = $urandom; cmd_ctrl_addr = 24'($urandom); cmd_ctrl_data = $urandom;
        cmd_last = 1'($urandom);
    endtask

    task automatic get_frame(output frame_t f);
        int n = 0;
        while (obs_q.size() == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_timeout: no frame after %0d cycles, required one", n);
            f.len = -1; f.bits = '0; f.cs_cycles = -1;
        end else begin
            f = obs_q.pop_front();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (load_cs !== 1'b1)   begin errors++; $display("FAIL reset_cs: got %b, required 1", load_cs); end
        checks++; if (load_clk !== 1'b0)  begin errors++; $display("FAIL reset_clk: got %b, required 0", load_clk); end
        checks++; if (load_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b, required 0", load_data); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_row_write();
        frame_t o, e;
        e.len = 64; e.bits = 256'({1'b0, 15'h0003, 16'h0005, 32'hA5A5_0F0F}); e.cs_cycles = 64 * 4 + 2;
        exp_q.push_back(e);
        send(2'd0, 15'h0003, 16'h0005, 32'hA5A5_0F0F, 24'h0, 32'h0, 1'b1);
        checks++; if (load_cs !== 1'b0)   begin errors++; $display("FAIL row_cs_after_accept: got %b, required 0", load_cs); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL row_busy: got %b, required 1", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL row_ready_in_shift: got %b, required 0", cmd_ready); end
        get_frame(o);
        e = exp_q.pop_front();
        checks++; if (o.len !== e.len) begin errors++; $display("FAIL row_edges: got %0d, required %0d", o.len, e.len); end
        checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL row_bits: got %h, required %h", o.bits, e.bits); end
        checks++; if (o.cs_cycles !== e.cs_cycles) begin errors++; $display("FAIL row_cs_low: got %0d, required %0d", o.cs_cycles, e.cs_cycles); end
        wait_idle();
    endtask

    task automatic test_ctrl_chain();
        frame_t o, e;
        e.len = 160; e.cs_cycles = 0;
        e.bits = 256'({1'b0, 15'h7FFF, 16'hFFFF, 8'h00, 24'h000012, 32'hDEADBEEF,
                       8'h00, 24'h000013, 32'h00000001});
        exp_q.push_back(e);
        send(2'd1, 15'h7FFF, 16'h1234, 32'h0, 24'h000012, 32'hDEADBEEF, 1'b0);
        send(2'd1, 15'h0042, 16'h0000, 32'h0, 24'h000013, 32'h00000001, 1'b1);
        get_frame(o);
        e = exp_q.pop_front();
        checks++; if (o.len !== e.len) begin errors++; $display("FAIL ctrl_len: got %0d, required %0d", o.len, e.len); end
        checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL ctrl_bits: got %h, required %h", o.bits, e.bits); end
        wait_idle();
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL ctrl_one_frame: extra frames %0d, required 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        frame_t o, e;
        e.len = 96; e.cs_cycles = 0;
        e.bits = 256'({1'b0, 15'h0011, 16'h0007, 32'h1234_5678, 32'h8000_0001});
        exp_q.push_back(e);
        send(2'd0, 15'h0011, 16'h0007, 32'h1234_5678, 24'h0, 32'h0, 1'b0);
        send(2'd0, 15'h0022, 16'h00AA, 32'h8000_0001, 24'h0, 32'h0, 1'b1);
        get_frame(o);
        e = exp_q.pop_front();
        checks++; if (o.len !== e.len) begin errors++; $display("FAIL cont_len: got %0d, required %0d", o.len, e.len); end
        checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL cont_bits: got %h, required %h", o.bits, e.bits); end
        wait_idle();
    endtask

    task automatic test_type_switch();
        frame_t o, e;
        e.len = 64; e.cs_cycles = 0;
        e.bits = 256'({1'b0, 15'h0005, 16'h0002, 32'hCAFE_F00D});
        exp_q.push_back(e);
        e.len = 96;
        e.bits = 256'({1'b0, 15'h0006, 16'hFFFF, 8'h00, 24'hABCDEF, 32'h0BAD_C0DE});
        exp_q.push_back(e);
        send(2'd0, 15'h0005, 16'h0002, 32'hCAFE_F00D, 24'h0, 32'h0, 1'b0);
        send(2'd1, 15'h0006, 16'h0003, 32'h0, 24'hABCDEF, 32'h0BAD_C0DE, 1'b1);
        for (int k = 0; k < 2; k++) begin
            get_frame(o);
            e = exp_q.pop_front();
            checks++; if (o.len !== e.len) begin errors++; $display("FAIL switch_len%0d: got %0d, required %0d", k, o.len, e.len); end
            checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL switch_bits%0d: got %h, required %h", k, o.bits, e.bits); end
        end
        checks++; if (last_gap < 2 * CLK_DIV) begin errors++; $display("FAIL switch_gap: got %0d cycles, required >= %0d", last_gap, 2 * CLK_DIV); end
        wait_idle();
    endtask

    task automatic test_enumerate();
        frame_t o, e;
        e.cs_cycles = 0;
        e.len = 4; e.bits = 256'(4'b1111);
        exp_q.push_back(e);
        e.len = 1; e.bits = 256'(1'b1);
        exp_q.push_back(e);
        send(2'd2, 15'd3, 16'h0, 32'h0, 24'h0, 32'h0, 1'b0);
        get_frame(o);
        e = exp_q.pop_front();
        checks++; if (o.len !== e.len) begin errors++; $display("FAIL enum3_len: got %0d, required %0d", o.len, e.len); end
        checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL enum3_bits: got %h, required %h", o.bits, e.bits); end
        wait_idle();
        send(2'd2, 15'd0, 16'h0, 32'h0, 24'h0, 32'h0, 1'b0);
        get_frame(o);
        e = exp_q.pop_front();
        checks++; if (o.len !== e.len) begin errors++; $display("FAIL enum0_len: got %0d, required %0d", o.len, e.len); end
        checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL enum0_bits: got %h, required %h", o.bits, e.bits); end
        wait_idle();
    endtask

    task automatic test_reserved();
        bit bad = 1'b0;
        send(2'd3, 15'h1111, 16'h2222, 32'h3333_4444, 24'h555555, 32'h6666_7777, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (load_cs !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL reserved_quiet: cs/busy activity seen, required cs=1 busy=0"); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reserved_ready: got %b, required 1", cmd_ready); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL reserved_frames: got %0d, required 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        frame_t o, e;
        int n = 0;
        send(2'd0, 15'h0001, 16'h0009, 32'hFFFF_0000, 24'h0, 32'h0, 1'b1);
        while (cur_len < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (cur_len < 20) begin errors++; $display("FAIL midreset_progress: got %0d bits, required 20", cur_len); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (load_cs !== 1'b1)   begin errors++; $display("FAIL midreset_cs: got %b, required 1", load_cs); end
        checks++; if (load_clk !== 1'b0)  begin errors++; $display("FAIL midreset_clk: got %b, required 0", load_clk); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b, required 1", cmd_ready); end
        repeat (2) @(negedge clk);
        obs_q.delete();
        e.len = 64; e.bits = 256'({1'b0, 15'h0004, 16'h0010, 32'h0F1E_2D3C}); e.cs_cycles = 64 * 4 + 2;
        exp_q.push_back(e);
        send(2'd0, 15'h0004, 16'h0010, 32'h0F1E_2D3C, 24'h0, 32'h0, 1'b1);
        get_frame(o);
        e = exp_q.pop_front();
        checks++; if (o.len !== e.len) begin errors++; $display("FAIL postreset_len: got %0d, required %0d", o.len, e.len); end
        checks++; if (o.bits !== e.bits) begin errors++; $display("FAIL postreset_bits: got %h, required %h", o.bits, e.bits); end
        checks++; if (o.cs_cycles !== e.cs_cycles) begin errors++; $display("FAIL postreset_cs_low: got %0d, required %0d", o.cs_cycles, e.cs_cycles); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_row_write();
        test_ctrl_chain();
        test_back_to_back();
        test_type_switch();
        test_enumerate();
        test_reserved();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
